fetch_sequencer: RTL and testbench

- Fetch controller that owns the program counter and sequences instruction-memory reads.
- Applies redirects from the branch/jump target unit (pc_src, target_address), squashing a wrong-path fetch that is in flight.
- Delivers one instruction at a time to decode over a valid/ready handshake.
- Sits between instruction memory, the next-PC logic and decode.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_perf_cnt.sv | 29 ++
 rtl/fetch_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_DELIVER = 2'd2,
      ST_ERROR   = 2'd3
   } fetch_state_t;
endpackage

// File: rtl/fetch_perf_cnt.sv
// Pair of saturating event counters for fetch statistics (FETCH_PERF_CNT_EN builds only).
module fetch_perf_cnt
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            i_inc_fetched,
   input  logic            i_inc_squashed,
   output logic [XLEN-1:0] o_fetched,
   output logic [XLEN-1:0] o_squashed
);
   logic [XLEN-1:0] r_fetched;
   logic [XLEN-1:0] r_squashed;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fetched  <= '0;
         r_squashed <= '0;
      end else begin
         if (i_inc_fetched && (r_fetched != '1))
            r_fetched <= r_fetched + 1'b1;
         if (i_inc_squashed && (r_squashed != '1))
            r_squashed <= r_squashed + 1'b1;
      end
   end

   assign o_fetched  = r_fetched;
   assign o_squashed = r_squashed;
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, sequences imem reads, applies redirects, delivers to decode.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned     WAIT_LIMIT = 255
)(
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            halt,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready,
   input  logic            pc_src,
   input  logic [XLEN-1:0] target_address,
   output logic            fetch_err
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [XLEN-1:0] perf_fetched,
   output logic [XLEN-1:0] perf_squashed
`endif
);
   localparam logic [16:0] LP_LIMIT = 17'(WAIT_LIMIT);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_squash;
   logic [15:0]     r_wait_cnt;
   logic            r_req;
   logic [XLEN-1:0] r_addr;
   logic            r_valid;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_instr_pc;
   logic            r_err;

   logic            w_ack;
   logic [16:0]     w_wait_next;
   logic            w_timeout;
   logic [XLEN-1:0] w_pc_inc;

   assign w_ack       = r_req & imem_ack;
   assign w_wait_next = {1'b0, r_wait_cnt} + 17'd1;
   assign w_timeout   = (w_wait_next >= LP_LIMIT);
   assign w_pc_inc    = r_pc + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_pc       <= RESET_PC;
         r_squash   <= 1'b0;
         r_wait_cnt <= '0;
         r_req      <= 1'b0;
         r_addr     <= RESET_PC;
         r_valid    <= 1'b0;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state    <= ST_FETCH;
                  r_req      <= 1'b1;
                  r_addr     <= r_pc;
                  r_wait_cnt <= '0;
               end
            end
            ST_FETCH: begin
               if (!r_req) begin
                  // Idle cycle after an ack: reissue, honouring a redirect arriving now.
                  r_req <= 1'b1;
                  if (pc_src) begin
                     r_pc   <= target_address;
                     r_addr <= target_address;
                  end else begin
                     r_addr <= r_pc;
                  end
               end else if (w_ack) begin
                  r_req      <= 1'b0;
                  r_wait_cnt <= '0;
                  r_squash   <= 1'b0;
                  if (pc_src) begin
                     r_pc <= target_address;
                  end else if (!r_squash) begin
                     r_instr    <= imem_rdata;
                     r_instr_pc <= r_pc;
                     r_pc       <= w_pc_inc;
                     r_valid    <= 1'b1;
                     r_state    <= ST_DELIVER;
                  end
               end else begin
                  if (pc_src) begin
                     r_pc     <= target_address;
                     r_squash <= 1'b1;
                  end
                  // A redirect defers the timeout by a cycle; the counter parks at the limit.
                  if (w_timeout && !pc_src) begin
                     r_state <= ST_ERROR;
                     r_req   <= 1'b0;
                     r_err   <= 1'b1;
                  end else if (!w_timeout) begin
                     r_wait_cnt <= w_wait_next[15:0];
                  end
               end
            end
            ST_DELIVER: begin
               if (pc_src) begin
                  r_pc    <= target_address;
                  r_valid <= 1'b0;
                  r_state <= ST_FETCH;
                  r_req   <= 1'b1;
                  r_addr  <= target_address;
               end else if (instr_ready) begin
                  r_valid <= 1'b0;
                  if (halt) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_FETCH;
                     r_req   <= 1'b1;
                     r_addr  <= r_pc;
                  end
               end
            end
            ST_ERROR: begin
               r_req   <= 1'b0;
               r_valid <= 1'b0;
               r_err   <= 1'b1;
            end
            default: r_state <= ST_ERROR;
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign instr_valid = r_valid;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign fetch_err   = r_err;

`ifdef FETCH_PERF_CNT_EN
   logic w_inc_fetched;
   logic w_inc_squashed;

   assign w_inc_fetched  = (r_state == ST_DELIVER) & instr_ready & ~pc_src;
   assign w_inc_squashed = ((r_state == ST_FETCH) & w_ack & (r_squash | pc_src)) |
                           ((r_state == ST_DELIVER) & pc_src);

   fetch_perf_cnt u_perf (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_inc_fetched  (w_inc_fetched),
      .i_inc_squashed (w_inc_squashed),
      .o_fetched      (perf_fetched),
      .o_squashed     (perf_squashed)
   );
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer (WAIT_LIMIT=4).
module tb_fetch_sequencer;
   import fetch_pkg::*;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            start, halt, imem_ack, instr_ready, pc_src;
   logic [31:0]     imem_rdata, target_address;
   logic            imem_req, instr_valid, fetch_err;
   logic [31:0]     imem_addr, instr, instr_pc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]     perf_fetched, perf_squashed;
`endif

   int total = 0;
   int bad   = 0;

   fetch_sequencer #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(4)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .halt           (halt),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .pc_src         (pc_src),
      .target_address (target_address),
      .fetch_err      (fetch_err)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_squashed  (perf_squashed)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 0; halt = 0; imem_ack = 0; instr_ready = 0;
      pc_src = 0; imem_rdata = '0; target_address = '0;
      tick(); tick();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
      total++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h/%h exp=0/0", instr, instr_pc); end
      total++; if (fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", fetch_err); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_sequential();
      instr_ready = 1; start = 1;
      tick();
      start = 0;
      for (int w = 0; w < 4; w++) begin
         total++; if (imem_req !== 1'b1 || imem_addr !== 32'(w)) begin bad++; $display("FAIL seq_issue w=%0d got=%b/%h exp=1/%h", w, imem_req, imem_addr, w); end
         for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'(w)) begin bad++; $display("FAIL seq_hold w=%0d got=%b/%h exp=1/%h", w, imem_req, imem_addr, w); end
         end
         imem_ack = 1; imem_rdata = 32'hC0DE_0000 + 32'(w);
         tick();
         imem_ack = 0;
         total++; if (instr_valid !== 1'b1 || instr_pc !== 32'(w)) begin bad++; $display("FAIL seq_pc w=%0d got=%b/%h exp=1/%h", w, instr_valid, instr_pc, w); end
         total++; if (instr !== 32'hC0DE_0000 + 32'(w)) begin bad++; $display("FAIL seq_instr got=%h exp=%h", instr, 32'hC0DE_0000 + 32'(w)); end
         total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL seq_req_drop got=%b exp=0", imem_req); end
         tick();
      end
   endtask

   task automatic test_redirect_fetch();
      imem_ack = 1; imem_rdata = 32'hC0DE_0004;
      tick();
      imem_ack = 0;
      total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL rf_pc4 got=%h exp=4", instr_pc); end
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h5) begin bad++; $display("FAIL rf_issue5 got=%b/%h exp=1/5", imem_req, imem_addr); end
      pc_src = 1; target_address = 32'h40;
      tick();
      pc_src = 0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h5) begin bad++; $display("FAIL rf_held got=%b/%h exp=1/5", imem_req, imem_addr); end
      imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 0;
      total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL rf_discard got=%b/%b exp=0/0", instr_valid, imem_req); end
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin bad++; $display("FAIL rf_reissue got=%b/%h/%b exp=1/40/0", imem_req, imem_addr, instr_valid); end
      imem_ack = 1; imem_rdata = 32'hC0DE_0040;
      tick();
      imem_ack = 0;
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'hC0DE_0040) begin bad++; $display("FAIL rf_deliver got=%b/%h/%h exp=1/40/c0de0040", instr_valid, instr_pc, instr); end
      tick();
   endtask

   task automatic test_redirect_deliver();
`ifdef FETCH_PERF_CNT_EN
      logic [31:0] snap_sq, snap_f;
`endif
      pc_src = 1; target_address = 32'h10;
      tick();
      pc_src = 0; imem_ack = 1; imem_rdata = 32'hDEAD_0041;
      tick();
      imem_ack = 0;
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin bad++; $display("FAIL rd_issue10 got=%b/%h exp=1/10", imem_req, imem_addr); end
      imem_ack = 1; imem_rdata = 32'hC0DE_0010;
      tick();
      imem_ack = 0;
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h10) begin bad++; $display("FAIL rd_pc10 got=%b/%h exp=1/10", instr_valid, instr_pc); end
`ifdef FETCH_PERF_CNT_EN
      snap_sq = perf_squashed; snap_f = perf_fetched;
`endif
      pc_src = 1; target_address = 32'h80; halt = 1;
      tick();
      pc_src = 0; halt = 0;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rd_kill got=%b exp=0", instr_valid); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin bad++; $display("FAIL rd_next80 got=%b/%h exp=1/80", imem_req, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
      total++; if (perf_squashed !== snap_sq + 32'd1) begin bad++; $display("FAIL rd_perf_sq got=%0d exp=%0d", perf_squashed, snap_sq + 32'd1); end
      total++; if (perf_fetched !== snap_f) begin bad++; $display("FAIL rd_perf_f got=%0d exp=%0d", perf_fetched, snap_f); end
`endif
      imem_ack = 1; imem_rdata = 32'hC0DE_0080;
      tick();
      imem_ack = 0;
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h80) begin bad++; $display("FAIL rd_pc80 got=%b/%h exp=1/80", instr_valid, instr_pc); end
   endtask

   task automatic test_stall();
      instr_ready = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h80 || instr !== 32'hC0DE_0080 || imem_req !== 1'b0) begin
            bad++; $display("FAIL stall k=%0d got=%b/%h/%h/%b exp=1/80/c0de0080/0", k, instr_valid, instr_pc, instr, imem_req); end
      end
      instr_ready = 1;
      tick();
      total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h81) begin bad++; $display("FAIL stall_release got=%b/%b/%h exp=0/1/81", instr_valid, imem_req, imem_addr); end
   endtask

   task automatic test_wrap();
      pc_src = 1; target_address = 32'hFFFF_FFFF;
      tick();
      pc_src = 0; imem_ack = 1; imem_rdata = 32'h0;
      tick();
      imem_ack = 0;
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_issue got=%b/%h exp=1/ffffffff", imem_req, imem_addr); end
      imem_ack = 1; imem_rdata = 32'h1234_5678;
      tick();
      imem_ack = 0;
      total++; if (instr_pc !== 32'hFFFF_FFFF || instr !== 32'h1234_5678) begin bad++; $display("FAIL wrap_deliver got=%h/%h exp=ffffffff/12345678", instr_pc, instr); end
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%b/%h exp=1/0", imem_req, imem_addr); end
   endtask

   task automatic test_halt();
      halt = 1; imem_ack = 1; imem_rdata = 32'hC0DE_0000;
      tick();
      imem_ack = 0;
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("FAIL halt_deliver got=%b/%h exp=1/0", instr_valid, instr_pc); end
      tick();
      halt = 0;
      total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL halt_idle got=%b/%b exp=0/0", instr_valid, imem_req); end
      pc_src = 1; target_address = 32'h99;
      tick();
      pc_src = 0;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_pcsrc got=%b exp=0", imem_req); end
      start = 1;
      tick();
      start = 0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h1) begin bad++; $display("FAIL halt_restart got=%b/%h exp=1/1", imem_req, imem_addr); end
   endtask

   task automatic test_async_reset();
      reset_n = 0;
      #1;
      total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL async_rst got=%b/%h/%b exp=0/0/0", imem_req, imem_addr, instr_valid); end
      tick();
      reset_n = 1;
      tick();
   endtask

   task automatic test_error();
      start = 1;
      tick();
      start = 0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL err_issue got=%b/%h exp=1/0", imem_req, imem_addr); end
      tick(); tick(); tick();
      total++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("FAIL err_early got=%b/%b exp=0/1", fetch_err, imem_req); end
      tick();
      total++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL err_set got=%b/%b/%b exp=1/0/0", fetch_err, imem_req, instr_valid); end
      start = 1; imem_ack = 1; pc_src = 1; target_address = 32'h5;
      tick(); tick(); tick();
      start = 0; imem_ack = 0; pc_src = 0;
      total++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL err_sticky got=%b/%b exp=1/0", fetch_err, imem_req); end
      reset_n = 0;
      tick();
      reset_n = 1;
      total++; if (fetch_err !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL err_clear got=%b/%h exp=0/0", fetch_err, imem_addr); end
      tick();
      start = 1;
      tick();
      start = 0;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL err_resetpc got=%b/%h exp=1/0", imem_req, imem_addr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_redirect_fetch();
      test_redirect_deliver();
      test_stall();
      test_wrap();
      test_halt();
      test_async_reset();
      test_error();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
